// File: rtl/capture_ctrl.sv
// Trigger/capture sequencer: writes a strobed sample stream into a
// circular RAM buffer and stops a programmed count after the trigger.
module capture_ctrl #(
  parameter int DEPTH = 512,
  parameter int DW    = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          rclk,
  input  logic          rst,
  input  logic          arm,
  input  logic          smpl_vld,
  input  logic [DW-1:0] smpl,
  input  logic [DW-1:0] trig_lvl,
  input  logic          trig_rise,
  input  logic [AW-1:0] post_cnt,
  output logic          en,
  output logic          we,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] wdata,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] trig_addr,
  output logic [AW-1:0] start_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_WAIT,
    S_POST,
    S_DONE
  } state_t;

  state_t        state;
  logic [AW-1:0] wp;
  logic [AW-1:0] cnt;
  logic [AW-1:0] rem;
  logic [AW-1:0] post_l;
  logic [DW-1:0] prev;
  logic          prev_vld;

  logic          capt;
  logic          acc;
  logic          hit;
  logic [AW-1:0] wp_nx;
  logic [AW-1:0] cnt_nx;
  logic [AW-1:0] pre_depth;

  assign capt = (state == S_PRE) || (state == S_WAIT) ||
                (state == S_POST);
  // arm has priority: a sample strobed with arm is dropped
  assign acc    = smpl_vld & ~arm & capt;
  assign wp_nx  = wp + 1'b1;
  assign cnt_nx = cnt + 1'b1;
  // DEPTH is a power of two, so DEPTH - post_l wraps to this
  assign pre_depth = '0 - post_l;

  always_comb begin
    hit = 1'b0;
    if (prev_vld) begin
      if (trig_rise)
        hit = (prev < trig_lvl) && (smpl >= trig_lvl);
      else
        hit = (prev >= trig_lvl) && (smpl < trig_lvl);
    end
  end

  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      en         <= 1'b0;
      we         <= 1'b0;
      addr       <= '0;
      wdata      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      trig_addr  <= '0;
      start_addr <= '0;
      wp         <= '0;
      cnt        <= '0;
      rem        <= '0;
      post_l     <= AW'(1);
      prev       <= '0;
      prev_vld   <= 1'b0;
    end else begin
      en <= acc;
      we <= acc;
      if (acc) begin
        addr     <= wp;
        wdata    <= smpl;
        wp       <= wp_nx;
        prev     <= smpl;
        prev_vld <= 1'b1;
      end
      if (arm) begin
        post_l   <= (post_cnt == '0) ? AW'(1) : post_cnt;
        cnt      <= '0;
        rem      <= '0;
        prev_vld <= 1'b0;
        done     <= 1'b0;
        busy     <= 1'b1;
        state    <= S_PRE;
      end else if (acc) begin
        case (state)
          S_PRE: begin
            cnt <= cnt_nx;
            if (cnt_nx == pre_depth)
              state <= S_WAIT;
          end
          S_WAIT: begin
            if (hit) begin
              trig_addr <= wp;
              if (post_l == AW'(1)) begin
                state      <= S_DONE;
                busy       <= 1'b0;
                done       <= 1'b1;
                start_addr <= wp_nx;
              end else begin
                rem   <= post_l - 1'b1;
                state <= S_POST;
              end
            end
          end
          S_POST: begin
            rem <= rem - 1'b1;
            if (rem == AW'(1)) begin
              state      <= S_DONE;
              busy       <= 1'b0;
              done       <= 1'b1;
              start_addr <= wp_nx;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl with a write scoreboard.
module tb_capture_ctrl;

  logic       rclk = 1'b0;
  logic       rst;
  logic       arm;
  logic       smpl_vld;
  logic [7:0] smpl;
  logic [7:0] trig_lvl;
  logic       trig_rise;
  logic [8:0] post_cnt;
  logic       en;
  logic       we;
  logic [8:0] addr;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [8:0] trig_addr;
  logic [8:0] start_addr;

  int total = 0;
  int bad   = 0;
  int wcnt  = 0;
  logic [8:0]  mwp = '0;
  logic [16:0] sb[$];
  logic [7:0]  v;

  capture_ctrl dut (
    .rclk       (rclk),
    .rst        (rst),
    .arm        (arm),
    .smpl_vld   (smpl_vld),
    .smpl       (smpl),
    .trig_lvl   (trig_lvl),
    .trig_rise  (trig_rise),
    .post_cnt   (post_cnt),
    .en         (en),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .trig_addr  (trig_addr),
    .start_addr (start_addr)
  );

  always #5 rclk = ~rclk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, check the result one negedge later.
  task automatic step(input logic a, input logic sv,
                      input logic [7:0] d, input logic p);
    logic [16:0] e;
    arm = a;
    smpl_vld = sv;
    smpl = d;
    if (p) begin
      sb.push_back({mwp, d});
      mwp = mwp + 1'b1;
    end
    @(negedge rclk);
    arm = 1'b0;
    smpl_vld = 1'b0;
    chk("we", 16'(we), 16'(p));
    chk("en", 16'(en), 16'(p));
    if (we) begin
      wcnt++;
      if (sb.size() == 0) begin
        chk("sb_underflow", 16'(sb.size()), 16'd1);
      end else begin
        e = sb.pop_front();
        chk("addr", 16'(addr), 16'(e[16:8]));
        chk("wdata", 16'(wdata), 16'(e[7:0]));
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_en"}, 16'(en), 16'd0);
    chk({tag, "_we"}, 16'(we), 16'd0);
    chk({tag, "_addr"}, 16'(addr), 16'd0);
    chk({tag, "_wdata"}, 16'(wdata), 16'd0);
    chk({tag, "_busy"}, 16'(busy), 16'd0);
    chk({tag, "_done"}, 16'(done), 16'd0);
    chk({tag, "_trig"}, 16'(trig_addr), 16'd0);
    chk({tag, "_start"}, 16'(start_addr), 16'd0);
  endtask

  initial begin
    rst = 1'b1;
    arm = 1'b0;
    smpl_vld = 1'b0;
    smpl = '0;
    trig_lvl = 8'h80;
    trig_rise = 1'b1;
    post_cnt = 9'd256;
    repeat (2) @(negedge rclk);
    chk_zero("rst");
    rst = 1'b0;
    step(0, 1, 8'h11, 0);

    // basic rising capture, trigger at index 300, wraps past 511
    wcnt = 0;
    step(1, 1, 8'hAA, 0);
    chk("b_busy", 16'(busy), 16'd1);
    for (int i = 0; i < 556; i++) begin
      v = (i < 300) ? 8'(i % 128) : 8'hC0;
      step(0, 1, v, 1);
      if (i == 554) chk("b_early", 16'(done), 16'd0);
    end
    chk("b_done", 16'(done), 16'd1);
    chk("b_busy0", 16'(busy), 16'd0);
    chk("b_trig", 16'(trig_addr), 16'd300);
    chk("b_start", 16'(start_addr), 16'd44);
    chk("b_wcnt", 16'(wcnt), 16'd556);
    for (int i = 0; i < 3; i++) step(0, 1, 8'h55, 0);
    chk("b_hold", 16'(done), 16'd1);

    // early crossing in PRE is ignored
    wcnt = 0;
    post_cnt = 9'd500;
    step(1, 0, 8'h00, 0);
    for (int i = 0; i < 520; i++) begin
      v = (i == 5 || i == 20) ? 8'h90 : 8'h10;
      step(0, 1, v, 1);
      if (i == 518) chk("e_early", 16'(done), 16'd0);
    end
    chk("e_done", 16'(done), 16'd1);
    chk("e_trig", 16'(trig_addr), 16'd64);
    chk("e_start", 16'(start_addr), 16'd52);
    chk("e_wcnt", 16'(wcnt), 16'd520);

    // falling edge: 0x40 is not below the level, 0x3F is
    post_cnt = 9'd3;
    trig_rise = 1'b0;
    trig_lvl = 8'h40;
    step(1, 0, 8'h00, 0);
    for (int i = 0; i < 514; i++) begin
      v = (i < 510) ? 8'h50 : ((i == 510) ? 8'h40 : 8'h3F);
      step(0, 1, v, 1);
      if (i == 510) chk("f_notrig", 16'(busy), 16'd1);
    end
    chk("f_done", 16'(done), 16'd1);
    chk("f_trig", 16'(trig_addr), 16'd51);
    chk("f_start", 16'(start_addr), 16'd54);

    // re-arm during WAIT restarts the pre count, wp continues
    post_cnt = 9'd256;
    trig_rise = 1'b1;
    trig_lvl = 8'h80;
    step(1, 0, 8'h00, 0);
    for (int i = 0; i < 300; i++) step(0, 1, 8'h10, 1);
    chk("r_busy", 16'(busy), 16'd1);
    step(1, 1, 8'hEE, 0);
    chk("r_done0", 16'(done), 16'd0);
    for (int i = 0; i < 512; i++) begin
      v = (i == 254 || i == 256) ? 8'h90 : 8'h10;
      step(0, 1, v, 1);
      if (i == 300) chk("r_mid", 16'(done), 16'd0);
    end
    chk("r_done", 16'(done), 16'd1);
    chk("r_trig", 16'(trig_addr), 16'd98);
    chk("r_start", 16'(start_addr), 16'd354);

    // post_cnt=1 with sparse strobes
    post_cnt = 9'd1;
    step(1, 0, 8'h00, 0);
    for (int i = 0; i < 512; i++) begin
      v = (i == 511) ? 8'h90 : 8'h10;
      step(0, 1, v, 1);
      if (i == 510) chk("s_pre", 16'(done), 16'd0);
      if (i == 511) chk("s_done", 16'(done), 16'd1);
      for (int k = 0; k < 3; k++) step(0, 0, 8'h00, 0);
    end
    chk("s_trig", 16'(trig_addr), 16'd353);
    chk("s_start", 16'(start_addr), 16'd354);

    // async reset in POST
    post_cnt = 9'd256;
    step(1, 0, 8'h00, 0);
    for (int i = 0; i < 300; i++) begin
      v = (i == 260) ? 8'h90 : 8'h10;
      step(0, 1, v, 1);
    end
    chk("p_busy", 16'(busy), 16'd1);
    rst = 1'b1;
    #1;
    chk_zero("arst");
    @(negedge rclk);
    rst = 1'b0;
    mwp = '0;
    for (int i = 0; i < 4; i++) step(0, 1, 8'h77, 0);
    step(1, 0, 8'h00, 0);
    step(0, 1, 8'h5A, 1);
    chk("p_sb", 16'(sb.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/capture_ctrl.md
Name: capture_ctrl

Overview:
- Trigger/capture sequencer for the scope front end, directly upstream of the 512 x 8 sample RAM interface.
- Accepts a strobed 8-bit ADC sample stream and writes it into the RAM as a circular buffer.
- Detects a level/edge trigger and stops after a programmed number of post-trigger samples.
- Reports the trigger address and the oldest-sample address so readout can unroll the buffer.

Parameters:
DEPTH, 512, buffer entries (power of two; address width AW = log2(DEPTH) = 9)
DW, 8, sample width

Ports:
rclk  in  1  system/RAM clock, rising edge
rst  in  1  asynchronous active-high reset
arm  in  1  one-cycle pulse; starts (or restarts) a capture
smpl_vld  in  1  one-cycle strobe, smpl valid this cycle
smpl  in  DW  ADC sample
trig_lvl  in  DW  trigger threshold (unsigned)
trig_rise  in  1  1 = rising-edge trigger, 0 = falling-edge trigger
post_cnt  in  AW  post-trigger samples incl. trigger sample, legal 1..DEPTH-1; latched on arm
en  out  1  RAM enable
we  out  1  RAM write enable
addr  out  AW  RAM address
wdata  out  DW  RAM write data
busy  out  1  capture in progress (PRE, WAIT, POST)
done  out  1  capture complete, held until next arm
trig_addr  out  AW  address holding the trigger sample
start_addr  out  AW  address of the oldest valid sample (= write pointer at completion)

Behaviour:
- Reset (async, rst=1): state IDLE; en=we=0, addr=0, wdata=0, busy=0, done=0, trig_addr=0, start_addr=0; write pointer wp=0, sample counter=0, prev-sample-valid=0.
- All outputs are registered.
- RAM write rules:
  - A sample accepted at edge N (smpl_vld=1 in PRE, WAIT or POST) gives en=we=1, addr=wp, wdata=smpl for exactly the cycle after edge N.
  - wp increments mod DEPTH (511 -> 0) at the same edge.
  - en=we=0 in all other cycles. No write ever occurs in IDLE or DONE.
- States:
  - IDLE: wait for arm.
  - PRE: write every sample. Count samples; move to WAIT once count reaches DEPTH - post_cnt_latched (the pre-trigger depth). Triggers are ignored in PRE.
  - WAIT: write every sample and evaluate the trigger on each one.
    - Rising: prev < trig_lvl and smpl >= trig_lvl.
    - Falling: prev >= trig_lvl and smpl < trig_lvl.
    - prev is the previous accepted sample since arm. No trigger is possible until one sample has been accepted (prev-valid).
    - On trigger: trig_addr <= wp (the trigger sample's address), load remaining = post_cnt_latched - 1, go to POST. If remaining = 0, go straight to DONE.
  - POST: write each sample and decrement remaining; when a sample is written with remaining = 1, go to DONE at that edge.
  - DONE: start_addr <= wp (already incremented past the last write); done=1, busy=0. Hold until arm.
- arm handling:
  - arm in any state (including mid-capture) restarts the capture: latch post_cnt, clear the sample counter, prev-valid, done and remaining; go to PRE; wp is not reset.
  - arm and smpl_vld in the same cycle: arm wins and that sample is dropped.
- Trigger settings: trig_lvl and trig_rise are sampled live each sample; they are not latched.
- Back-to-back smpl_vld on consecutive cycles is supported at full rate, one write per cycle.
- Illegal post_cnt=0 is treated as 1.
- busy=1 exactly in PRE, WAIT and POST.

Test Plan:
- Reset mid-capture: assert rst in POST -> all outputs 0 immediately (async); no writes until the next arm.
- Basic capture: post_cnt=256, rising edge, trig_lvl=0x80.
  - Stimulus: arm; feed a ramp 0x00.. every cycle; crossing at sample index 300.
  - Response: pre depth 256 met; trig_addr=300; done asserts after sample 555; start_addr=556 mod 512=44; exactly 556 we pulses with addr=wdata order matching.
- Early trigger ignored: post_cnt=500 (pre=12).
  - Stimulus: crossing at sample 5, second crossing at sample 20.
  - Response: trig_addr=20; done after sample 519.
- Falling edge, trig_lvl=0x40.
  - Stimulus: samples 0x50,0x40,0x3F after the pre depth is filled.
  - Response: triggers on 0x3F only (0x40 is not below the level).
- Re-arm mid-capture: arm during WAIT at wp=100 -> next write at addr=100; pre count restarts from 0; done stays 0.
- Boundary settings:
  - post_cnt=1: trigger sample is the last write; done the edge after the trigger sample; start_addr=trig_addr+1.
  - Sparse smpl_vld (every 4th cycle): writes occur only on the cycle after each strobe.
